// File: rtl/kronos_counter_ctrl_if.sv
// CSR read/write port of the machine counter bank.
// The CSR unit drives the request side; the counter controller answers with ack/err/data.
interface kronos_counter_ctrl_if;
  logic        csr_req;
  logic        csr_we;
  logic [2:0]  csr_sel;
  logic        csr_hi;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        csr_ack;
  logic        csr_err;

  modport master (
    output csr_req, csr_we, csr_sel, csr_hi, csr_wr_data,
    input  csr_rd_data, csr_ack, csr_err
  );

  modport slave (
    input  csr_req, csr_we, csr_sel, csr_hi, csr_wr_data,
    output csr_rd_data, csr_ack, csr_err
  );
endinterface

// File: rtl/kronos_counter_ctrl.sv
// Machine counter bank: split 32-bit halves with a one-cycle staggered carry.
// Reads fold the pending carry in; CSR writes take priority over event increments.
module kronos_counter_ctrl #(
  parameter int NUM_CNT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CNT-1:0]   cnt_incr,
  input  logic [NUM_CNT-1:0]   cnt_inhibit,
  kronos_counter_ctrl_if.slave csr_if,
  output logic [NUM_CNT-1:0]   cnt_ovf
);

  typedef enum logic {IDLE, ACK} state_e;

  state_e                    state_q, state_d;
  logic [NUM_CNT-1:0][31:0]  low_q, low_d;
  logic [NUM_CNT-1:0][31:0]  high_q, high_d;
  logic [NUM_CNT-1:0]        carry_q, carry_d;
  logic [NUM_CNT-1:0]        ovf_q, ovf_d;
  logic [31:0]               rd_data_q, rd_data_d;
  logic                      err_q, err_d;
  logic                      acc;
  logic                      sel_ok;
  logic [31:0]               rd_mux;

  // Only IDLE samples a request, so accesses are spaced at least two cycles apart.
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: if (csr_if.csr_req) begin
        acc     = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sel_ok = int'({29'd0, csr_if.csr_sel}) < NUM_CNT;

  // High-half reads include the not-yet-applied carry so software sees a coherent value.
  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_if.csr_sel == i[2:0])
        rd_mux = csr_if.csr_hi ? high_q[i] + {31'd0, carry_q[i]} : low_q[i];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (acc && !csr_if.csr_we) rd_data_d = rd_mux;
    err_d = acc && !sel_ok;
  end

  always_comb begin
    low_d   = low_q;
    high_d  = high_q;
    carry_d = '0;
    ovf_d   = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (acc && csr_if.csr_we && !csr_if.csr_hi && csr_if.csr_sel == i[2:0]) begin
        low_d[i] = csr_if.csr_wr_data;
      end else if (cnt_incr[i] && !cnt_inhibit[i]) begin
        low_d[i]   = low_q[i] + 32'd1;
        carry_d[i] = &low_q[i];
      end
      // A high-half write overrides a pending carry, including its overflow pulse.
      if (acc && csr_if.csr_we && csr_if.csr_hi && csr_if.csr_sel == i[2:0]) begin
        high_d[i] = csr_if.csr_wr_data;
      end else if (carry_q[i]) begin
        high_d[i] = high_q[i] + 32'd1;
        ovf_d[i]  = &high_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      low_q     <= '0;
      high_q    <= '0;
      carry_q   <= '0;
      ovf_q     <= '0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      low_q     <= low_d;
      high_q    <= high_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign csr_if.csr_ack     = (state_q == ACK);
  assign csr_if.csr_err     = err_q;
  assign csr_if.csr_rd_data = rd_data_q;
  assign cnt_ovf            = ovf_q;

endmodule

// File: tb/tb_kronos_counter_ctrl.sv
// Bench for kronos_counter_ctrl: 64-bit reference counters plus directed literal checks.
module tb_kronos_counter_ctrl;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cnt_incr = '0;
  logic [N-1:0] cnt_inhibit = '0;
  logic [N-1:0] cnt_ovf;

  kronos_counter_ctrl_if bus ();

  kronos_counter_ctrl #(.NUM_CNT(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_incr    (cnt_incr),
    .cnt_inhibit (cnt_inhibit),
    .csr_if      (bus),
    .cnt_ovf     (cnt_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each counter is one 64-bit value; a wrap shows up on cnt_ovf one cycle later.
  logic [63:0]  mval [N];
  logic [N-1:0] mwrap;
  logic         m_ack, m_err;
  logic [31:0]  m_rd;
  logic [N-1:0] m_ovf;

  always @(posedge clk or posedge rst) begin
    logic         acc, hw, lw, nw;
    logic [63:0]  v;
    logic [N-1:0] n_ovf, n_wrap;
    if (rst) begin
      for (int i = 0; i < N; i++) mval[i] <= 64'd0;
      mwrap <= '0; m_ack <= 1'b0; m_err <= 1'b0; m_rd <= 32'd0; m_ovf <= '0;
    end else begin
      acc    = !m_ack && bus.csr_req;
      n_ovf  = '0;
      n_wrap = '0;
      for (int i = 0; i < N; i++) begin
        v  = mval[i];
        hw = acc && bus.csr_we && bus.csr_hi && int'(bus.csr_sel) == i;
        lw = acc && bus.csr_we && !bus.csr_hi && int'(bus.csr_sel) == i;
        nw = 1'b0;
        if (mwrap[i] && !hw) n_ovf[i] = 1'b1;
        if (hw) v[63:32] = bus.csr_wr_data;
        if (lw) v[31:0] = bus.csr_wr_data;
        else if (cnt_incr[i] && !cnt_inhibit[i]) begin
          nw = (v == 64'hFFFF_FFFF_FFFF_FFFF);
          v  = v + 64'd1;
        end
        n_wrap[i] = nw;
        mval[i] <= v;
      end
      mwrap <= n_wrap;
      m_ovf <= n_ovf;
      m_ack <= acc;
      m_err <= acc && int'(bus.csr_sel) >= N;
      if (acc && !bus.csr_we) begin
        if (int'(bus.csr_sel) < N)
          m_rd <= bus.csr_hi ? mval[bus.csr_sel][63:32] : mval[bus.csr_sel][31:0];
        else
          m_rd <= 32'd0;
      end
    end
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack", {31'd0, bus.csr_ack}, {31'd0, m_ack});
      chk("err", {31'd0, bus.csr_err}, {31'd0, m_err});
      chk("rd_data", bus.csr_rd_data, m_rd);
      chk("ovf", {{(32-N){1'b0}}, cnt_ovf}, {{(32-N){1'b0}}, m_ovf});
    end
  end

  task automatic access(input bit we, input int sel, input bit hi, input logic [31:0] wd,
                        input logic [N-1:0] incpulse, output logic [31:0] rd, output logic err);
    bit got = 0;
    bus.csr_req = 1'b1; bus.csr_we = we; bus.csr_sel = sel[2:0];
    bus.csr_hi = hi; bus.csr_wr_data = wd;
    cnt_incr = cnt_incr | incpulse;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk); #1;
      cnt_incr = cnt_incr & ~incpulse;
      if (bus.csr_ack) got = 1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 6 cycles");
    end
    rd  = bus.csr_rd_data;
    err = bus.csr_err;
    bus.csr_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int sel, input bit hi, input logic [31:0] wd);
    logic [31:0] r; logic e;
    access(1'b1, sel, hi, wd, '0, r, e);
  endtask

  task automatic rd_chk(input string nm, input int sel, input bit hi, input logic [31:0] exp);
    logic [31:0] r; logic e;
    access(1'b0, sel, hi, 32'd0, '0, r, e);
    chk(nm, r, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          acks, pairs;
    bit          prev;
    bus.csr_req = 1'b0; bus.csr_we = 1'b0; bus.csr_sel = 3'd0;
    bus.csr_hi = 1'b0; bus.csr_wr_data = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'd0, bus.csr_ack}, 32'd0);
    chk("rst_err", {31'd0, bus.csr_err}, 32'd0);
    chk("rst_rd", bus.csr_rd_data, 32'd0);
    chk("rst_ovf", {{(32-N){1'b0}}, cnt_ovf}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // free-run mcycle for exactly 10 edges
    cnt_incr[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 cnt_incr[0] = 1'b0;
    rd_chk("freerun_lo", 0, 1'b0, 32'd10);
    rd_chk("freerun_hi", 0, 1'b1, 32'd0);

    // staggered rollover, high read on the carry-pending edge
    wr(0, 1'b0, 32'hFFFF_FFFF);
    wr(0, 1'b1, 32'h1234_5678);
    cnt_incr[0] = 1'b1;
    @(posedge clk); #1 cnt_incr[0] = 1'b0;
    rd_chk("stagger_hi_pend", 0, 1'b1, 32'h1234_5679);
    rd_chk("stagger_hi_next", 0, 1'b1, 32'h1234_5679);
    rd_chk("stagger_lo", 0, 1'b0, 32'h0000_0000);

    // full 64-bit wrap: overflow two cycles after the increment
    wr(0, 1'b1, 32'hFFFF_FFFF);
    wr(0, 1'b0, 32'hFFFF_FFFF);
    cnt_incr[0] = 1'b1;
    @(posedge clk); #1 cnt_incr[0] = 1'b0;
    @(negedge clk); chk("wrap_ovf_c1", {31'd0, cnt_ovf[0]}, 32'd0);
    @(negedge clk); chk("wrap_ovf_c2", {31'd0, cnt_ovf[0]}, 32'd1);
    @(negedge clk); chk("wrap_ovf_c3", {31'd0, cnt_ovf[0]}, 32'd0);
    @(posedge clk); #1;
    rd_chk("wrap_hi", 0, 1'b1, 32'd0);
    rd_chk("wrap_lo", 0, 1'b0, 32'd0);

    // low write wins over a concurrent increment
    access(1'b1, 1, 1'b0, 32'h0000_0100, 2'b10, r, e);
    rd_chk("coll_lo", 1, 1'b0, 32'h0000_0100);

    // high write on the carry-pending edge drops the carry
    wr(1, 1'b0, 32'hFFFF_FFFF);
    wr(1, 1'b1, 32'h0000_0010);
    cnt_incr[1] = 1'b1;
    @(posedge clk); #1 cnt_incr[1] = 1'b0;
    wr(1, 1'b1, 32'h0000_0007);
    rd_chk("coll_hi", 1, 1'b1, 32'h0000_0007);
    rd_chk("coll_hi_lo", 1, 1'b0, 32'h0000_0000);

    // inhibit masks increments; release gives +3
    cnt_inhibit[1] = 1'b1; cnt_incr[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1 cnt_incr[1] = 1'b0;
    rd_chk("inh_lo", 1, 1'b0, 32'd0);
    rd_chk("inh_hi", 1, 1'b1, 32'd7);
    cnt_inhibit[1] = 1'b0; cnt_incr[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 cnt_incr[1] = 1'b0;
    rd_chk("inh_rel_lo", 1, 1'b0, 32'd3);

    // invalid select
    access(1'b1, 5, 1'b0, 32'hDEAD_BEEF, '0, r, e);
    chk("inv_wr_err", {31'd0, e}, 32'd1);
    rd_chk("inv_c0_lo", 0, 1'b0, 32'd0);
    rd_chk("inv_c1_lo", 1, 1'b0, 32'd3);
    access(1'b0, 2, 1'b1, 32'd0, '0, r, e);
    chk("inv_rd_data", r, 32'd0);
    chk("inv_rd_err", {31'd0, e}, 32'd1);

    // held request: acks on alternate cycles only
    cnt_incr[0] = 1'b1;
    bus.csr_req = 1'b1; bus.csr_we = 1'b0; bus.csr_sel = 3'd0; bus.csr_hi = 1'b0;
    acks = 0; pairs = 0; prev = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.csr_ack && prev) pairs++;
      if (bus.csr_ack) acks++;
      prev = bus.csr_ack;
    end
    bus.csr_req = 1'b0; cnt_incr[0] = 1'b0;
    chk("b2b_acks", acks, 32'd5);
    chk("b2b_consecutive", pairs, 32'd0);
    repeat (2) @(posedge clk); #1;

    // reset during the ack cycle aborts the access
    bus.csr_req = 1'b1; bus.csr_we = 1'b0; bus.csr_sel = 3'd1; bus.csr_hi = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, bus.csr_ack}, 32'd0);
    chk("midrst_rd", bus.csr_rd_data, 32'd0);
    bus.csr_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    rd_chk("midrst_c1_lo", 1, 1'b0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/kronos_counter_ctrl.md
Name: kronos_counter_ctrl

Overview:
Controller for the machine counter bank (mcycle, minstret and optional hpmcounters). Each counter is held as two 32-bit halves with a staggered carry: the low half rolls over and the high half increments one cycle later. The block folds the pending carry into every read and arbitrates event increments against CSR writes. It sits beside the CSR unit in the write-back stage and serves the CSR read/write port.

Parameters:
NUM_CNT, 2, number of 64-bit counters implemented (1..8); index 0 = mcycle, index 1 = minstret.

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
cnt_incr  input  NUM_CNT  per-counter increment event for this cycle
cnt_inhibit  input  NUM_CNT  per-counter inhibit (mcountinhibit); masks cnt_incr
csr_req  input  1  CSR access request, held until csr_ack
csr_we  input  1  1 = write, 0 = read; stable while csr_req is high
csr_sel  input  3  counter index
csr_hi  input  1  1 = high half, 0 = low half
csr_wr_data  input  32  write data (final value; the CSR unit has already applied RW/RS/RC)
csr_rd_data  output  32  read data, valid with csr_ack
csr_ack  output  1  one-cycle completion pulse
csr_err  output  1  pulses with csr_ack when csr_sel >= NUM_CNT
cnt_ovf  output  NUM_CNT  one-cycle pulse when a 64-bit counter wraps to 0

Behaviour:
- Reset (async, rst=1):
  - all counter halves = 0; carry_pend = 0.
  - csr_ack, csr_err, cnt_ovf = 0; csr_rd_data = 0; FSM = IDLE.
  - Reset asserted mid-access aborts the access with no ack.
- Increment, per counter i, when inc_i = cnt_incr[i] & ~cnt_inhibit[i]:
  - low <= low + 1.
  - If low == 32'hFFFF_FFFF, set carry_pend[i] for the next cycle.
- Carry: if carry_pend[i] is set, next cycle high <= high + 1 and carry_pend[i] clears. Increments to low continue meanwhile.
  - If high was 32'hFFFF_FFFF, high wraps to 0 and cnt_ovf[i] pulses in that same cycle.
- FSM has two states:
  - IDLE: csr_req=1 samples csr_we/sel/hi/wr_data -> ACK. The action below is performed on this sampling edge.
  - ACK: csr_ack=1 for exactly one cycle -> IDLE. A new request is not sampled in ACK, so accesses are spaced at least 2 cycles apart. The requester drops csr_req in the ack cycle or issues the next request.
- Read (sampled edge):
  - csr_rd_data <= low, or high + carry_pend[i] (mod 2^32) when csr_hi=1.
  - Values are pre-increment for that edge.
  - Read latency is 1 cycle (data with ack).
- Write (sampled edge):
  - Low-half write: low <= csr_wr_data. A concurrent inc_i for that counter is dropped, and no carry is generated from it.
  - High-half write: high <= csr_wr_data and carry_pend[i] clears (the write overrides the carry). Concurrent low increments proceed normally.
  - csr_rd_data is unchanged on writes.
- Invalid select (csr_sel >= NUM_CNT): read returns 0, write is ignored, csr_err pulses with csr_ack.
- Inhibit mid-carry: a pending carry still completes. Inhibit gates only new increments.
- Arithmetic is 32-bit modulo per half. The 64-bit value is {high, low} once no carry is pending.

Test Plan:
- Reset then free-run: cnt_incr[0]=1 for 10 cycles -> read mcycle low returns 10 (±0 with sampling-edge semantics); high reads 0.
- Stagger rollover: write low=FFFF_FFFF, high=1234_5678; pulse inc once, then read high on the carry-pending edge -> 1234_5679; next-cycle read also -> 1234_5679; low -> 0.
- 64-bit wrap: high=FFFF_FFFF, low=FFFF_FFFF, one inc -> cnt_ovf[0] pulses 2 cycles later; both halves read 0.
- Write vs increment collision: write low=0000_0100 on the same edge as inc -> low reads 0000_0100, not 101. High write on the carry-pending edge with 0000_0007 -> high = 0000_0007 (carry dropped).
- Inhibit: cnt_inhibit[1]=1 with cnt_incr[1]=1 for 20 cycles -> minstret unchanged; release and 3 incs -> +3.
- Invalid select and spacing: csr_sel=5 write of DEAD_BEEF -> csr_err=1 with ack and no counter changes. Back-to-back held csr_req -> acks every 2nd cycle, never consecutive.
